// File: rtl/key_sched_pkg.sv
// key_sched_pkg: shared types and helpers for the key_sched_stream round-key
// generator.
//   SK_W      : subkey width in bits
//   MAX_KEY_W : widest supported master key (32 bytes)
//   state_t   : scheduler FSM encoding (IDLE, RUN, DONE)
//   key_byte  : MSB-first byte select from a left-justified master key
package key_sched_pkg;

  localparam int SK_W      = 8;
  localparam int MAX_KEY_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // The key must be left-justified in MAX_KEY_W bits so that byte 0 always
  // sits in the top byte, whatever the real key length is.
  function automatic logic [SK_W-1:0] key_byte(input logic [MAX_KEY_W-1:0] key,
                                               input logic [4:0]           idx);
    return SK_W'(key >> (MAX_KEY_W - SK_W - 8 * int'(idx)));
  endfunction

endpackage

// File: rtl/key_sched_stream_sk_lane.sv
// sk_lane: one subkey lane, K(n) = n[7:0] XOR key_byte[(n-1) mod KEY_BYTES].
//   n_lo : low 8 bits of the subkey index n
//   kb   : selected master key byte
//   sk   : resulting subkey
module sk_lane
  import key_sched_pkg::*;
(
  input  logic [SK_W-1:0] n_lo,
  input  logic [SK_W-1:0] kb,
  output logic [SK_W-1:0] sk
);

  assign sk = n_lo ^ kb;

endmodule

// File: rtl/key_sched_stream.sv
// key_sched_stream: loadable-key round-key generator. Emits NUM_OUT 8-bit
// subkeys per batch over a valid/ready stream, NUM_BATCH batches per key,
// then reports done.
//   CLK, RST   : clock, synchronous active-high reset
//   key_load   : capture key_in (restarts the schedule, drops a pending batch)
//   key_in     : master key, byte 0 in the top byte
//   en         : permit issuing the next batch
//   sk_ready   : consumer accepts sk_out
//   sk_valid   : sk_out holds a batch
//   sk_out     : lane j at [8j+7:8j]
//   batch_idx  : batches issued since the last key load
//   done       : final batch accepted
//   dbg_state  : FSM state for observation
//
// Handshake: a batch transfers on any rising edge where sk_valid && sk_ready.
// While sk_valid && !sk_ready, sk_out is held stable. A new batch may be
// registered in the same cycle the current one transfers.
module key_sched_stream
  import key_sched_pkg::*;
#(
  parameter int NUM_OUT   = 3,
  parameter int KEY_BYTES = 16,
  parameter int NUM_BATCH = 16
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic                               key_load,
  input  logic [8*KEY_BYTES-1:0]             key_in,
  input  logic                               en,
  input  logic                               sk_ready,
  output logic                               sk_valid,
  output logic [8*NUM_OUT-1:0]               sk_out,
  output logic [$clog2(NUM_BATCH+1)-1:0]     batch_idx,
  output logic                               done,
  output logic [1:0]                         dbg_state
);

  localparam int BI_W = $clog2(NUM_BATCH + 1);
  localparam int KI_W = $clog2(KEY_BYTES);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_DONE = DONE;

  logic [1:0]             state_q;
  logic [8*KEY_BYTES-1:0] key_q;
  // base_m = (index of lane 0 of the next batch) - 1, kept modulo 256.
  // Both n[7:0] and (n-1) mod KEY_BYTES only depend on n modulo 256 because
  // KEY_BYTES is a power of two no larger than 32, so 8 bits suffice.
  logic [7:0]             base_m;
  logic [MAX_KEY_W-1:0]   key_wide;
  logic [8*NUM_OUT-1:0]   sk_next;
  logic                   accept;
  logic                   last_out;
  logic                   issue;

  assign key_wide = MAX_KEY_W'(key_q) << (MAX_KEY_W - 8 * KEY_BYTES);

  assign accept   = sk_valid && sk_ready;
  assign last_out = (batch_idx == BI_W'(NUM_BATCH));
  assign issue    = (state_q == S_RUN) && en && (!sk_valid || sk_ready) && !last_out;

  for (genvar j = 0; j < NUM_OUT; j++) begin : g_lane
    logic [7:0]      lane_m;
    logic [7:0]      lane_n;
    logic [SK_W-1:0] lane_kb;

    assign lane_m  = base_m + 8'(j);
    assign lane_n  = lane_m + 8'd1;
    assign lane_kb = key_byte(key_wide, 5'(lane_m[KI_W-1:0]));

    sk_lane u_lane (
      .n_lo (lane_n),
      .kb   (lane_kb),
      .sk   (sk_next[8*j +: 8])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      key_q     <= '0;
      base_m    <= '0;
      sk_valid  <= 1'b0;
      sk_out    <= '0;
      batch_idx <= '0;
    end else if (key_load) begin
      state_q   <= S_RUN;
      key_q     <= key_in;
      base_m    <= '0;
      sk_valid  <= 1'b0;
      batch_idx <= '0;
    end else if (state_q == S_RUN) begin
      if (issue) begin
        sk_out    <= sk_next;
        sk_valid  <= 1'b1;
        batch_idx <= batch_idx + 1'b1;
        base_m    <= base_m + 8'(NUM_OUT);
      end else if (accept) begin
        sk_valid <= 1'b0;
        // Nothing more can be issued once the final batch has gone out.
        if (last_out) state_q <= S_DONE;
      end
    end
  end

  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule
